avalon_reg_bank: RTL

- Parametrised Avalon-MM slave register bank: successor to the fixed 3×32-bit scratch-register peripheral.
- Adds configurable width and depth, byte enables, registered reads with readdatavalid, and a W1C event/interrupt block.
- Adds a saturating write counter.
- Sits on the Nios II data master bus as a custom peripheral; hardware events come from the surrounding user logic.

---
 rtl/avalon_reg_bank.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/avalon_reg_bank.sv
// ----------------------------------------------------------------------------
// avalon_reg_bank
//
// Avalon-MM slave register bank. It sits on the Nios II data master as a
// custom peripheral and provides:
//   - NUM_REGS general-purpose read/write registers with byte enables
//   - a STATUS register with sticky hardware events and write-1-to-clear
//   - an IRQ_EN mask and a registered, level-sensitive interrupt
//   - a saturating WRCOUNT register that counts mapped writes; any write
//     to WRCOUNT clears it
//
// Word address map:
//   0 .. NUM_REGS-1   GP[n]     RW
//   NUM_REGS          STATUS    W1C; set by i_hw_event
//   NUM_REGS+1        IRQ_EN    RW
//   NUM_REGS+2        WRCOUNT   RO; a write clears it
//   above             unmapped  reads return 0, writes are ignored
//
// Ports:
//   i_clk              system clock; all logic runs on the rising edge
//   i_reset            synchronous, active-high reset
//   i_address          word address
//   i_chipselect       slave select
//   i_read             read strobe, qualified by i_chipselect
//   i_write            write strobe, qualified by i_chipselect
//   i_byteenable       per-byte write enable
//   i_writedata        write data
//   o_readdata         registered read data; holds between reads
//   o_readdatavalid    one-cycle pulse qualifying o_readdata
//   i_hw_event         level-sampled event inputs, one per STATUS bit
//   o_irq              registered interrupt request (level)
// ----------------------------------------------------------------------------
module avalon_reg_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_chipselect,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W/8-1:0] i_byteenable,
    input  logic [DATA_W-1:0]   i_writedata,
    output logic [DATA_W-1:0]   o_readdata,
    output logic                o_readdatavalid,
    input  logic [DATA_W-1:0]   i_hw_event,
    output logic                o_irq
);

    localparam int unsigned NumBytes = DATA_W / 8;

    localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] AddrIrqEn   = ADDR_W'(NUM_REGS + 1);
    localparam logic [ADDR_W-1:0] AddrWrCount = ADDR_W'(NUM_REGS + 2);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_gp [NUM_REGS];
    logic [DATA_W-1:0] r_status;
    logic [DATA_W-1:0] r_irq_en;
    logic [DATA_W-1:0] r_wrcount;
    logic [DATA_W-1:0] r_readdata;
    logic              r_readdatavalid;
    logic              r_irq;

    // ------------------------------------------------------------------------
    // Access qualification and decode
    // ------------------------------------------------------------------------
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [NUM_REGS-1:0] w_sel_gp;
    logic                w_sel_status;
    logic                w_sel_irq_en;
    logic                w_sel_wrcount;
    logic                w_counted;
    logic [DATA_W-1:0]   w_be_mask;
    logic [DATA_W-1:0]   w_status_clr;
    logic [DATA_W-1:0]   w_rd_data;

    // A simultaneous write wins; the read is dropped entirely.
    assign w_wr_acc = i_chipselect & i_write;
    assign w_rd_acc = i_chipselect & i_read & ~i_write;

    always_comb begin
        w_sel_gp = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            w_sel_gp[n] = (i_address == ADDR_W'(n));
        end
    end

    assign w_sel_status  = (i_address == AddrStatus);
    assign w_sel_irq_en  = (i_address == AddrIrqEn);
    assign w_sel_wrcount = (i_address == AddrWrCount);

    // Writes that bump WRCOUNT: every mapped address except WRCOUNT itself.
    assign w_counted = (|w_sel_gp) | w_sel_status | w_sel_irq_en;

    // Expand byte enables into a bit mask over the data word.
    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < NumBytes; b++) begin
            w_be_mask[8*b +: 8] = {8{i_byteenable[b]}};
        end
    end

    assign w_status_clr = (w_wr_acc && w_sel_status) ? (i_writedata & w_be_mask) : '0;

    // Read mux; unmapped addresses fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (w_sel_gp[n]) begin
                w_rd_data = r_gp[n];
            end
        end
        if (w_sel_status) begin
            w_rd_data = r_status;
        end
        if (w_sel_irq_en) begin
            w_rd_data = r_irq_en;
        end
        if (w_sel_wrcount) begin
            w_rd_data = r_wrcount;
        end
    end

    // ------------------------------------------------------------------------
    // General-purpose registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                r_gp[n] <= '0;
            end
        end else if (w_wr_acc) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (w_sel_gp[n]) begin
                    r_gp[n] <= (r_gp[n] & ~w_be_mask) | (i_writedata & w_be_mask);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // IRQ_EN
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_en <= '0;
        end else if (w_wr_acc && w_sel_irq_en) begin
            r_irq_en <= (r_irq_en & ~w_be_mask) | (i_writedata & w_be_mask);
        end
    end

    // ------------------------------------------------------------------------
    // STATUS: event set is applied after the clear so a same-cycle event wins.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | i_hw_event;
        end
    end

    // ------------------------------------------------------------------------
    // WRCOUNT: saturating counter of mapped writes, cleared by writing it.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrcount <= '0;
        end else if (w_wr_acc && w_sel_wrcount) begin
            r_wrcount <= '0;
        end else if (w_wr_acc && w_counted && (r_wrcount != '1)) begin
            r_wrcount <= r_wrcount + DATA_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Read return path: one-cycle latency, data holds between reads.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_readdata <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt: registered from the current STATUS and mask.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_status & r_irq_en);
        end
    end

    assign o_readdata      = r_readdata;
    assign o_readdatavalid = r_readdatavalid;
    assign o_irq           = r_irq;

endmodule
